// File: rtl/mem_stage_if.sv
// Signal bundle around mem_stage: execute results in, data-memory port, MEM/WB results out.
// The slave modport is the stage itself; the master modport is the surrounding pipeline/memory.
interface mem_stage_if #(
    parameter int DW = 32
);
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] ALUout;
    logic [DW-1:0] BB;
    logic [4:0]    Rw;
    logic [31:0]   newPC;
    logic          Zero;
    logic          Overflow;
    logic          MW;
    logic          BR;
    logic          MR;
    logic          RW;

    logic          stall;
    logic          pc_src;
    logic [31:0]   branch_target;

    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;

    logic          wb_valid;
    logic          wb_regwr;
    logic [4:0]    wb_rw;
    logic [DW-1:0] wb_data;
    logic          exc_ovf;
    logic          exc_align;
    logic          bus_err;

    modport slave (
        input  flush, ex_valid, ALUout, BB, Rw, newPC, Zero, Overflow, MW, BR, MR, RW,
               dmem_ack, dmem_rdata,
        output stall, pc_src, branch_target, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               wb_valid, wb_regwr, wb_rw, wb_data, exc_ovf, exc_align, bus_err
    );

    modport master (
        output flush, ex_valid, ALUout, BB, Rw, newPC, Zero, Overflow, MW, BR, MR, RW,
               dmem_ack, dmem_rdata,
        input  stall, pc_src, branch_target, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               wb_valid, wb_regwr, wb_rw, wb_data, exc_ovf, exc_align, bus_err
    );
endinterface

// File: rtl/mem_stage.sv
// EX/MEM pipeline register plus data-memory access stage driving registered MEM/WB outputs.
// Define MEM_TIMEOUT_EN to abort a request after TIMEOUT cycles without ack (bus_err pulse).
//   state | meaning
//   IDLE  | no access outstanding; non-memory instructions retire here
//   REQ   | dmem_req held, waiting for dmem_ack
module mem_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    mem_stage_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t        state_q;
    logic          em_valid_q;
    logic [DW-1:0] em_alu_q;
    logic [DW-1:0] em_bb_q;
    logic [4:0]    em_rw_q;
    logic [31:0]   em_npc_q;
    logic          em_zero_q, em_ovf_q, em_mw_q, em_br_q, em_mr_q, em_regwr_q;

    logic          wb_valid_q, wb_regwr_q, exc_ovf_q, exc_align_q, bus_err_q;
    logic [4:0]    wb_rw_q;
    logic [DW-1:0] wb_data_q;

    logic          mem_instr, misaligned, mem_op, timeout, stall, retire, wb_regwr_d;
    logic [DW-1:0] wb_data_d;

    assign mem_instr  = em_valid_q & (em_mw_q | em_mr_q);
    assign misaligned = mem_instr & (em_alu_q[1:0] != 2'b00);
    assign mem_op     = mem_instr & ~misaligned;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    assign timeout = (state_q == REQ) & ~bus.dmem_ack & (tmo_cnt_q == 8'(TIMEOUT - 1));

    // Held at zero while idle, so it reads 0 in the first REQ cycle.
    always_ff @(posedge clock) begin
        if (reset || state_q == IDLE) tmo_cnt_q <= '0;
        else                          tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        stall  = 1'b0;
        retire = 1'b0;
        case (state_q)
            IDLE: begin
                stall  = mem_op;
                retire = em_valid_q & ~mem_op;
            end
            REQ: begin
                stall  = ~bus.dmem_ack & ~timeout;
                retire = ~stall;
            end
            default: ;
        endcase
        wb_regwr_d = retire & em_regwr_q & ~em_ovf_q & ~em_mw_q & ~misaligned & ~timeout;
        wb_data_d  = em_mr_q ? bus.dmem_rdata : em_alu_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            em_valid_q  <= 1'b0;
            em_alu_q    <= '0;
            em_bb_q     <= '0;
            em_rw_q     <= '0;
            em_npc_q    <= '0;
            em_zero_q   <= 1'b0;
            em_ovf_q    <= 1'b0;
            em_mw_q     <= 1'b0;
            em_br_q     <= 1'b0;
            em_mr_q     <= 1'b0;
            em_regwr_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_regwr_q  <= 1'b0;
            wb_rw_q     <= '0;
            wb_data_q   <= '0;
            exc_ovf_q   <= 1'b0;
            exc_align_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            // A flush seen while stalled is dropped; the in-flight access must finish first.
            if (!stall) begin
                em_valid_q <= bus.ex_valid & ~bus.flush;
                em_alu_q   <= bus.ALUout;
                em_bb_q    <= bus.BB;
                em_rw_q    <= bus.Rw;
                em_npc_q   <= bus.newPC;
                em_zero_q  <= bus.Zero;
                em_ovf_q   <= bus.Overflow;
                em_mw_q    <= bus.MW;
                em_br_q    <= bus.BR;
                em_mr_q    <= bus.MR;
                em_regwr_q <= bus.RW;
            end
            case (state_q)
                IDLE:    if (mem_op) state_q <= REQ;
                REQ:     if (!stall) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            wb_valid_q  <= retire;
            wb_regwr_q  <= wb_regwr_d;
            exc_ovf_q   <= retire & em_ovf_q;
            exc_align_q <= retire & misaligned;
            bus_err_q   <= timeout;
            if (retire) begin
                wb_rw_q   <= em_rw_q;
                wb_data_q <= wb_data_d;
            end
        end
    end

    assign bus.stall         = stall;
    assign bus.pc_src        = em_valid_q & em_br_q & em_zero_q;
    assign bus.branch_target = em_npc_q;
    assign bus.dmem_req      = (state_q == REQ);
    assign bus.dmem_we       = em_mw_q;
    assign bus.dmem_addr     = em_alu_q;
    assign bus.dmem_wdata    = em_bb_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_regwr      = wb_regwr_q;
    assign bus.wb_rw         = wb_rw_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.exc_ovf       = exc_ovf_q;
    assign bus.exc_align     = exc_align_q;
    assign bus.bus_err       = bus_err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks and memory requests are queued on issue,
// a monitor and a memory responder pop and compare them as the DUT produces them.
module tb_mem_stage;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_stage_if #(.DW(DW)) bus ();
    mem_stage #(.DW(DW), .TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic valid; logic [31:0] alu, bb, npc; logic [4:0] rw;
        logic zero, ovf, mw, br, mr, regw;
    } ins_t;
    typedef struct {
        logic [4:0] rw; logic regwr; logic [31:0] data; logic chkdata;
        logic ovf, align, berr; int stalls;
    } exp_t;
    typedef struct { logic we; logic [31:0] addr, wdata; int lat; } req_t;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    req_t req_q[$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];
    ins_t cur, em_cur, em_next;
    int   cur_lat;
    logic accepted;
    int   stall_cnt;
    logic busy;
    int   waited;
    req_t r_cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : mem_init(a);
    endfunction

    function automatic ins_t mk(input logic v, input logic [31:0] alu, input logic [31:0] bb,
                                input logic [4:0] rw, input logic [31:0] npc, input logic zero,
                                input logic ovf, input logic mw, input logic br, input logic mr,
                                input logic regw);
        ins_t i;
        i.valid = v; i.alu = alu; i.bb = bb; i.rw = rw; i.npc = npc; i.zero = zero;
        i.ovf = ovf; i.mw = mw; i.br = br; i.mr = mr; i.regw = regw;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        int k;
        k = $urandom_range(0, 5);
        i = mk(k != 0, $urandom, $urandom, 5'($urandom), $urandom, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        case (k)
            2: begin i.mr = 1'b1; i.alu = {24'h0, 6'($urandom), 2'b00}; end
            3: begin i.mw = 1'b1; i.alu = {24'h0, 6'($urandom), 2'b00}; end
            4: i.br = 1'b1;
            5: begin
                if ($urandom_range(0, 1) == 1) i.mr = 1'b1;
                else                           i.mw = 1'b1;
                i.alu = {24'h0, 6'($urandom), 2'($urandom_range(1, 3))};
            end
            default: ;
        endcase
        return i;
    endfunction

    // Reference behaviour of one instruction entering the stage.
    task automatic accept(input ins_t i, input int lat);
        exp_t e;
        logic mis, al, tmo;
        mis = (i.mw | i.mr) && (i.alu[1:0] != 2'b00);
        al  = (i.mw | i.mr) && !mis;
        tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
        tmo = al && (lat >= TO);
`endif
        e.rw = i.rw; e.ovf = i.ovf; e.align = mis; e.berr = tmo;
        e.regwr = i.regw && !i.ovf && !i.mw && !mis && !tmo;
        e.data = i.alu; e.chkdata = !(i.mr && (mis || tmo));
        e.stalls = !al ? 0 : (tmo ? TO : 1 + lat);
        if (al && !tmo) begin
            if (i.mr) e.data = ref_rd(i.alu);
            else      ref_mem[i.alu] = i.bb;
        end
        if (al) req_q.push_back('{we: i.mw, addr: i.alu, wdata: i.bb, lat: lat});
        exp_q.push_back(e);
    endtask

    task automatic drive(input ins_t i);
        bus.ex_valid = i.valid; bus.ALUout = i.alu; bus.BB = i.bb; bus.Rw = i.rw;
        bus.newPC = i.npc; bus.Zero = i.zero; bus.Overflow = i.ovf; bus.MW = i.mw;
        bus.BR = i.br; bus.MR = i.mr; bus.RW = i.regw;
    endtask

    task automatic step();
        @(negedge clock);
        if (!bus.stall) begin
            accepted = 1'b1;
            em_next = cur;
            em_next.valid = cur.valid & ~bus.flush;
            if (em_next.valid) accept(cur, cur_lat);
        end else begin
            accepted = 1'b0;
            em_next = em_cur;
        end
        @(posedge clock); #1;
        em_cur = em_next;
    endtask

    task automatic send(input ins_t i, input int lat, input logic rflush);
        int n;
        n = 0;
        cur = i; cur_lat = lat; drive(i);
        bus.flush = rflush && ($urandom_range(0, 7) == 0);
        do begin
            step();
            n++;
            if (!accepted) bus.flush = rflush && ($urandom_range(0, 7) == 0);
        end while (!accepted && n < 100);
        if (!accepted) fail("accept_timeout");
        bus.flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            send(mk(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0, 1'b0);
            n++;
        end
        if (exp_q.size() != 0) fail("drain_wb_pending");
        chk("req_q_empty", 64'(req_q.size()), 64'd0);
    endtask

    // Data memory: pops the expected request when a new access starts, acks after its latency.
    initial begin
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        busy = 1'b0;
        waited = 0;
        r_cur = '{we: 1'b0, addr: 0, wdata: 0, lat: 0};
        forever begin
            @(posedge clock); #1;
            bus.dmem_ack = 1'b0;
            bus.dmem_rdata = $urandom;
            if (!bus.dmem_req || reset) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    waited = 0;
                    if (req_q.size() == 0) begin
                        fail("dmem_req_unexpected");
                        r_cur = '{we: bus.dmem_we, addr: bus.dmem_addr, wdata: bus.dmem_wdata, lat: 0};
                    end else begin
                        r_cur = req_q.pop_front();
                        chk("dmem_we", 64'(bus.dmem_we), 64'(r_cur.we));
                        chk("dmem_addr", 64'(bus.dmem_addr), 64'(r_cur.addr));
                        if (r_cur.we) chk("dmem_wdata", 64'(bus.dmem_wdata), 64'(r_cur.wdata));
                    end
                end
                if (waited == r_cur.lat) begin
                    bus.dmem_ack = 1'b1;
                    if (r_cur.we) phys_mem[r_cur.addr] = r_cur.wdata;
                    else          bus.dmem_rdata = phys_rd(r_cur.addr);
                end else begin
                    waited++;
                end
            end
        end
    end

    // Writeback / branch monitor.
    initial begin
        stall_cnt = 0;
        forever begin
            @(negedge clock);
            if (reset !== 1'b0) continue;
            chk("pc_src", 64'(bus.pc_src), 64'(em_cur.valid & em_cur.br & em_cur.zero));
            chk("branch_target", 64'(bus.branch_target), 64'(em_cur.npc));
            if (bus.wb_valid) begin
                if (exp_q.size() == 0) begin
                    fail("wb_valid_unexpected");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_rw", 64'(bus.wb_rw), 64'(e.rw));
                    chk("wb_regwr", 64'(bus.wb_regwr), 64'(e.regwr));
                    if (e.chkdata) chk("wb_data", 64'(bus.wb_data), 64'(e.data));
                    chk("exc_ovf", 64'(bus.exc_ovf), 64'(e.ovf));
                    chk("exc_align", 64'(bus.exc_align), 64'(e.align));
                    chk("bus_err", 64'(bus.bus_err), 64'(e.berr));
                    chk("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
                end
                stall_cnt = 0;
            end else begin
                chk("idle_pulses", {60'd0, bus.wb_regwr, bus.exc_ovf, bus.exc_align, bus.bus_err}, 64'd0);
            end
            if (!(em_cur.valid && (em_cur.mw | em_cur.mr) && em_cur.alu[1:0] == 2'b00))
                chk("no_stall_nonmem", 64'(bus.stall), 64'd0);
            if (bus.stall) stall_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0;
        cur = mk(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(cur);
        em_cur = cur;
        em_next = cur;
        cur_lat = 0;
        accepted = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
        chk("rst_dmem_we", 64'(bus.dmem_we), 64'd0);
        chk("rst_dmem_addr", 64'(bus.dmem_addr), 64'd0);
        chk("rst_dmem_wdata", 64'(bus.dmem_wdata), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_wb_rw", 64'(bus.wb_rw), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
        @(posedge clock); #1;

        ref_mem[32'h10]  = 32'hDEAD_BEEF;
        phys_mem[32'h10] = 32'hDEAD_BEEF;
        send(mk(1'b1, 32'd5,  0,        5'd3, 0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 0, 1'b0);
        send(mk(1'b1, 32'h10, 0,        5'd7, 0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 2, 1'b0);
        send(mk(1'b1, 32'h20, 32'h1234, 5'd9, 0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 0, 1'b0);
        send(mk(1'b1, 32'h13, 0,        5'd4, 0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 0, 1'b0);
        send(mk(1'b1, 32'h0,  0,        5'd0, 32'h40,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 0, 1'b0);
        send(mk(1'b1, 32'h7,  0,        5'd5, 0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 0, 1'b0);
        send(mk(1'b1, 32'h20, 0,        5'd6, 0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1, 1'b0);
        drain();

        for (int n = 0; n < 400; n++) send(rand_ins(), $urandom_range(0, 4), 1'b1);
        drain();

`ifdef MEM_TIMEOUT_EN
        send(mk(1'b1, 32'h44, 0, 5'd8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 40, 1'b0);
        drain();
`endif

        // Reset while a load waits in REQ: request drops the next cycle, access abandoned.
        send(mk(1'b1, 32'h30, 0, 5'd2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 8, 1'b0);
        cur = mk(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(cur);
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("req_before_rst", 64'(bus.dmem_req), 64'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        em_cur = cur;
        em_next = cur;
        exp_q.delete();
        req_q.delete();
        stall_cnt = 0;
        @(negedge clock);
        chk("rst_mid_dmem_req", 64'(bus.dmem_req), 64'd0);
        chk("rst_mid_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_mid_stall", 64'(bus.stall), 64'd0);
        @(posedge clock); #1;
        send(mk(1'b1, 32'h55, 0, 5'd11, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 0, 1'b0);
        send(mk(1'b1, 32'h30, 0, 5'd12, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 3, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
